// File: rtl/run_ctrl_pkg.sv
// Shared command/state encodings for the CPU run-control sequencer.
package run_ctrl_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_NOP    = 3'd0,
      OP_STEP   = 3'd1,
      OP_RUN    = 3'd2,
      OP_HALT   = 3'd3,
      OP_SET_BP = 3'd4,
      OP_CLR_BP = 3'd5
   } cmd_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_STEP = 2'd1,
      ST_RUN  = 2'd2,
      ST_WAIT = 2'd3
   } state_e;

   // Ops that may still be taken while pulses are being sequenced.
   function automatic logic busy_op_ok(input logic [OP_W-1:0] op);
      return (op == OP_HALT) || (op == OP_SET_BP) || (op == OP_CLR_BP);
   endfunction

endpackage

// File: rtl/bp_match.sv
// Compares pc against the enabled breakpoint addresses; lowest index wins.
module bp_match #(
   parameter int BP_NUM = 2
)(
   input  logic [31:0]             i_pc,
   input  logic [BP_NUM-1:0]       i_bp_en,
   input  logic [BP_NUM-1:0][31:0] i_bp_addr,
   output logic                    o_hit,
   output logic [1:0]              o_idx
);

   // Scan high to low so the lowest matching index is the one left standing.
   always_comb begin
      o_hit = 1'b0;
      o_idx = 2'd0;
      for (int i = BP_NUM - 1; i >= 0; i--) begin
         if (i_bp_en[i] && (i_pc == i_bp_addr[i])) begin
            o_hit = 1'b1;
            o_idx = 2'(i);
         end else begin
            o_hit = o_hit;
            o_idx = o_idx;
         end
      end
   end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Debug run-control: turns step/run/halt commands into a spaced stream of
// one-clock CPU enable pulses, stopping on an enabled PC breakpoint.
module cpu_run_ctrl
   import run_ctrl_pkg::*;
#(
   parameter int BP_NUM = 2,
   parameter int GAP    = 2,
   parameter int CNT_W  = 16
)(
   input  logic             clk,
   input  logic             rstn,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [OP_W-1:0]  cmd_op,
   input  logic [1:0]       cmd_idx,
   input  logic [31:0]      cmd_arg,
   input  logic [31:0]      pc,
   output logic             cpu_step,
   output logic             busy,
   output logic             bp_hit,
   output logic [1:0]       bp_which,
   output logic [CNT_W-1:0] retired
);

   localparam int               GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP - 1);

   state_e                   r_state, r_ret;
   logic [CNT_W-1:0]         r_remaining, r_retired;
   logic [GAP_W-1:0]         r_gap;
   logic                     r_first, r_cpu_step, r_busy, r_bp_hit;
   logic [1:0]               r_bp_which;
   logic [BP_NUM-1:0]        r_bp_en;
   logic [BP_NUM-1:0][31:0]  r_bp_addr;

   state_e                   w_state_nx, w_ret_nx;
   logic [CNT_W-1:0]         w_rem_nx, w_step_cnt;
   logic [GAP_W-1:0]         w_gap_nx;
   logic                     w_first_nx, w_pulse, w_bp_hit_nx;
   logic [1:0]               w_bp_which_nx, w_hit_idx;
   logic                     w_accept, w_halt, w_hit;

   bp_match #(.BP_NUM(BP_NUM)) u_bp_match (
      .i_pc      (pc),
      .i_bp_en   (r_bp_en),
      .i_bp_addr (r_bp_addr),
      .o_hit     (w_hit),
      .o_idx     (w_hit_idx)
   );

   assign cmd_ready  = (r_state == ST_IDLE) ? 1'b1 : busy_op_ok(cmd_op);
   assign w_accept   = cmd_valid && cmd_ready;
   assign w_halt     = w_accept && (cmd_op == OP_HALT);
   assign w_step_cnt = (cmd_arg[CNT_W-1:0] == {CNT_W{1'b0}}) ? CNT_W'(1) : cmd_arg[CNT_W-1:0];

   // Next-state and pulse decision; HALT always pre-empts a pulse or a breakpoint stop.
   always_comb begin
      w_state_nx    = r_state;
      w_ret_nx      = r_ret;
      w_rem_nx      = r_remaining;
      w_gap_nx      = r_gap;
      w_first_nx    = r_first;
      w_bp_hit_nx   = r_bp_hit;
      w_bp_which_nx = r_bp_which;
      w_pulse       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept && (cmd_op == OP_STEP)) begin
               w_state_nx  = ST_STEP;
               w_rem_nx    = w_step_cnt;
               w_bp_hit_nx = 1'b0;
            end else if (w_accept && (cmd_op == OP_RUN)) begin
               w_state_nx  = ST_RUN;
               w_first_nx  = 1'b1;
               w_bp_hit_nx = 1'b0;
            end else begin
               w_state_nx  = ST_IDLE;
            end
         end
         ST_STEP: begin
            if (w_halt) begin
               w_state_nx = ST_IDLE;
            end else begin
               w_pulse    = 1'b1;
               w_rem_nx   = r_remaining - CNT_W'(1);
               w_ret_nx   = (r_remaining == CNT_W'(1)) ? ST_IDLE : ST_STEP;
               w_gap_nx   = GAP_LOAD;
               w_state_nx = ST_WAIT;
            end
         end
         ST_RUN: begin
            if (w_halt) begin
               w_state_nx = ST_IDLE;
            end else if (w_hit && !r_first) begin
               w_state_nx    = ST_IDLE;
               w_bp_hit_nx   = 1'b1;
               w_bp_which_nx = w_hit_idx;
            end else begin
               w_pulse    = 1'b1;
               w_first_nx = 1'b0;
               w_ret_nx   = ST_RUN;
               w_gap_nx   = GAP_LOAD;
               w_state_nx = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (w_halt) begin
               w_state_nx = ST_IDLE;
            end else if (r_gap == {GAP_W{1'b0}}) begin
               w_state_nx = r_ret;
            end else begin
               w_gap_nx   = r_gap - GAP_W'(1);
            end
         end
         default: begin
            w_state_nx = ST_IDLE;
         end
      endcase
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= ST_IDLE;
         r_ret       <= ST_IDLE;
         r_remaining <= {CNT_W{1'b0}};
         r_gap       <= {GAP_W{1'b0}};
         r_first     <= 1'b0;
         r_cpu_step  <= 1'b0;
         r_busy      <= 1'b0;
         r_bp_hit    <= 1'b0;
         r_bp_which  <= 2'd0;
         r_retired   <= {CNT_W{1'b0}};
      end else begin
         r_state     <= w_state_nx;
         r_ret       <= w_ret_nx;
         r_remaining <= w_rem_nx;
         r_gap       <= w_gap_nx;
         r_first     <= w_first_nx;
         r_cpu_step  <= w_pulse;
         r_busy      <= (w_state_nx != ST_IDLE);
         r_bp_hit    <= w_bp_hit_nx;
         r_bp_which  <= w_bp_which_nx;
         r_retired   <= w_pulse ? (r_retired + CNT_W'(1)) : r_retired;
      end
   end

   // Breakpoint registers; an index with no register behind it is dropped.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_bp_en   <= {BP_NUM{1'b0}};
         r_bp_addr <= {(BP_NUM * 32){1'b0}};
      end else begin
         for (int i = 0; i < BP_NUM; i++) begin
            if (w_accept && (cmd_idx == 2'(i)) && (cmd_op == OP_SET_BP)) begin
               r_bp_en[i]   <= 1'b1;
               r_bp_addr[i] <= cmd_arg;
            end else if (w_accept && (cmd_idx == 2'(i)) && (cmd_op == OP_CLR_BP)) begin
               r_bp_en[i]   <= 1'b0;
            end
         end
      end
   end

   assign cpu_step = r_cpu_step;
   assign busy     = r_busy;
   assign bp_hit   = r_bp_hit;
   assign bp_which = r_bp_which;
   assign retired  = r_retired;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: expected pulse cycles are queued when a
// command is sent and popped by a monitor whenever cpu_step is seen high.
module tb_cpu_run_ctrl;
   import run_ctrl_pkg::*;

   localparam int GAP   = 2;
   localparam int CNT_W = 16;
   localparam int SP    = GAP + 1;

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [2:0]       cmd_op = 3'd0;
   logic [1:0]       cmd_idx = 2'd0;
   logic [31:0]      cmd_arg = 32'd0;
   logic [31:0]      pc = 32'd0;
   logic             pc_clr = 1'b0;
   logic             cpu_step, busy, bp_hit;
   logic [1:0]       bp_which;
   logic [CNT_W-1:0] retired;

   int cyc = 0;
   int checks = 0;
   int failures = 0;
   int exp_ret = 0;
   int exp_q[$];

   typedef struct {
      logic [31:0] arg;
      int          pulses;
      int          fall;
   } step_vec_t;
   step_vec_t vecs [6];

   cpu_run_ctrl #(.BP_NUM(2), .GAP(GAP), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_idx   (cmd_idx),
      .cmd_arg   (cmd_arg),
      .pc        (pc),
      .cpu_step  (cpu_step),
      .busy      (busy),
      .bp_hit    (bp_hit),
      .bp_which  (bp_which),
      .retired   (retired)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // CPU model: pc advances by one instruction on every enable pulse.
   always @(posedge clk) begin
      if (pc_clr) pc <= 32'd0;
      else if (cpu_step) pc <= pc + 32'd4;
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rstn && cpu_step) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pulse_unexpected actual=pulse@%0d required=no_pulse", cyc);
         end else begin
            chk("pulse_cycle", cyc, exp_q.pop_front());
         end
      end
   end

   task automatic send(input logic [2:0] op, input logic [1:0] idx, input logic [31:0] arg,
                       input int at, output int a);
      @(negedge clk);
      while (cyc < at) @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_idx   = idx;
      cmd_arg   = arg;
      #1 chk("cmd_ready", cmd_ready, 1);
      @(posedge clk);
      #1;
      a         = cyc;
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      cmd_idx   = 2'd0;
      cmd_arg   = 32'd0;
   endtask

   task automatic push_pulses(input int a, input int n);
      for (int k = 0; k < n; k++) exp_q.push_back(a + 1 + k * SP);
      exp_ret += n;
   endtask

   task automatic wait_idle(output int c);
      int n = 0;
      @(negedge clk);
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (busy) chk("busy_timeout", 1, 0);
      c = cyc;
   endtask

   task automatic drain();
      repeat (4) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      exp_q.delete();
      chk("retired", retired, exp_ret);
   endtask

   task automatic clear_pc();
      @(negedge clk);
      pc_clr = 1'b1;
      @(negedge clk);
      pc_clr = 1'b0;
   endtask

   initial begin
      int a, b, c, h;
      vecs[0] = '{arg: 32'd3,          pulses: 3, fall: 3 * SP};
      vecs[1] = '{arg: 32'd0,          pulses: 1, fall: 1 * SP};
      vecs[2] = '{arg: 32'd1,          pulses: 1, fall: 1 * SP};
      vecs[3] = '{arg: 32'd5,          pulses: 5, fall: 5 * SP};
      vecs[4] = '{arg: 32'h0001_0000,  pulses: 1, fall: 1 * SP};
      vecs[5] = '{arg: 32'hFFFF_0002,  pulses: 2, fall: 2 * SP};

      #1;
      chk("rst_cpu_step", cpu_step, 0);
      chk("rst_busy", busy, 0);
      chk("rst_bp_hit", bp_hit, 0);
      chk("rst_bp_which", bp_which, 0);
      chk("rst_retired", retired, 0);
      chk("rst_ready", cmd_ready, 1);
      repeat (2) @(negedge clk);
      rstn = 1'b1;

      // STEP counts from the table
      for (int i = 0; i < 6; i++) begin
         send(OP_STEP, 2'd0, vecs[i].arg, 0, a);
         push_pulses(a, vecs[i].pulses);
         wait_idle(c);
         chk("step_busy_fall", c - a, vecs[i].fall);
         drain();
      end

      // reserved opcode in IDLE is a no-op
      send(3'd7, 2'd0, 32'd5, 0, a);
      chk("reserved_op_busy", busy, 0);
      drain();

      // breakpoint at 0x10 stops RUN after four pulses
      send(OP_SET_BP, 2'd0, 32'h10, 0, a);
      clear_pc();
      send(OP_RUN, 2'd0, 32'd0, 0, a);
      push_pulses(a, 4);
      cmd_op = OP_STEP;
      #1 chk("ready_busy_step", cmd_ready, 0);
      cmd_op = OP_CLR_BP;
      #1 chk("ready_busy_clr", cmd_ready, 1);
      cmd_op = 3'd0;
      wait_idle(c);
      chk("bp_stop_cycle", c - a, 4 * SP + 1);
      chk("bp_hit_set", bp_hit, 1);
      chk("bp_which0", bp_which, 0);
      chk("bp_stop_pc", pc, 32'h10);
      drain();

      // resume from the breakpoint PC, clear it, then halt
      send(OP_RUN, 2'd0, 32'd0, 0, b);
      push_pulses(b, 1);
      send(OP_CLR_BP, 2'd0, 32'd0, 0, a);
      send(OP_HALT, 2'd0, 32'd0, 0, h);
      chk("halt_busy", busy, 0);
      chk("halt_bp_hit", bp_hit, 0);
      drain();
      chk("resume_pc", pc, 32'h14);

      // two breakpoints on the same address: lowest index reported
      send(OP_SET_BP, 2'd0, 32'h8, 0, a);
      send(OP_SET_BP, 2'd1, 32'h8, 0, a);
      send(OP_SET_BP, 2'd2, 32'h4, 0, a);
      clear_pc();
      send(OP_RUN, 2'd0, 32'd0, 0, a);
      push_pulses(a, 2);
      wait_idle(c);
      chk("tie_stop_cycle", c - a, 2 * SP + 1);
      chk("tie_bp_hit", bp_hit, 1);
      chk("tie_bp_which", bp_which, 0);
      drain();

      // STEP ignores breakpoints and clears bp_hit
      send(OP_STEP, 2'd0, 32'd1, 0, a);
      push_pulses(a, 1);
      wait_idle(c);
      chk("step_at_bp_fall", c - a, SP);
      chk("step_clears_bp_hit", bp_hit, 0);
      drain();

      // only idx1 left: stop reports index 1
      send(OP_CLR_BP, 2'd0, 32'd0, 0, a);
      clear_pc();
      send(OP_RUN, 2'd0, 32'd0, 0, a);
      push_pulses(a, 2);
      wait_idle(c);
      chk("idx1_stop_cycle", c - a, 2 * SP + 1);
      chk("idx1_bp_hit", bp_hit, 1);
      chk("idx1_bp_which", bp_which, 1);
      drain();

      // HALT in the same cycle as the breakpoint match
      clear_pc();
      send(OP_RUN, 2'd0, 32'd0, 0, a);
      push_pulses(a, 2);
      send(OP_HALT, 2'd0, 32'd0, a + 2 * SP, h);
      chk("halt_match_accept", h - a, 2 * SP + 1);
      chk("halt_match_busy", busy, 0);
      chk("halt_match_bp_hit", bp_hit, 0);
      drain();

      // asynchronous reset while a pulse is high
      clear_pc();
      send(OP_RUN, 2'd0, 32'd0, 0, a);
      push_pulses(a, 1);
      @(negedge clk);
      @(negedge clk);
      chk("pulse_before_reset", cpu_step, 1);
      #2 rstn = 1'b0;
      #1;
      chk("async_step_drop", cpu_step, 0);
      chk("async_busy", busy, 0);
      chk("async_retired", retired, 0);
      exp_q.delete();
      exp_ret = 0;
      @(negedge clk);
      rstn   = 1'b1;
      cmd_op = OP_STEP;
      #1 chk("post_reset_ready", cmd_ready, 1);
      cmd_op = 3'd0;

      // breakpoints were wiped: RUN passes pc 0x8 and is halted by hand
      clear_pc();
      send(OP_RUN, 2'd0, 32'd0, 0, a);
      push_pulses(a, 3);
      send(OP_HALT, 2'd0, 32'd0, a + 2 * SP + 1, h);
      chk("no_bp_busy", busy, 0);
      chk("no_bp_hit", bp_hit, 0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
